// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared fp16 field widths, special encodings and types
package fp16_pkg;

   localparam int FP16_W = 16;
   localparam int EXP_W  = 5;
   localparam int MANT_W = 10;

   typedef logic [FP16_W-1:0] fp16_t;

   localparam fp16_t FP16_QNAN = 16'h7E00;
   localparam fp16_t FP16_PINF = 16'h7C00;
   localparam fp16_t FP16_ZERO = 16'h0000;

   // True for any NaN encoding: all-ones exponent with a non-zero mantissa
   function automatic logic fp16_is_nan(input fp16_t v);
      return (v[FP16_W-2 -: EXP_W] == '1) && (v[MANT_W-1:0] != '0);
   endfunction

endpackage

// File: rtl/fp16_res_fifo.sv
// rtl/fp16_res_fifo.sv - first-word fall-through result FIFO with wrap-bit pointers
module fp16_res_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra MSB on each pointer tells a full FIFO apart from an empty one
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // Storage is not reset; only the pointers decide what is valid
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // Pointer advance; a push into a full FIFO is dropped so the head is never corrupted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/fp16pipe_stream.sv
// rtl/fp16pipe_stream.sv - valid/ready stream wrapper around a free-running fp16 pipe
module fp16pipe_stream
   import fp16_pkg::*;
#(
   parameter int LATENCY    = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [FP16_W-1:0] s_a,
   input  logic [FP16_W-1:0] s_b,
   output logic [FP16_W-1:0] pipe_a,
   output logic [FP16_W-1:0] pipe_b,
   input  logic [FP16_W-1:0] pipe_res,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [FP16_W-1:0] m_res,
   output logic              o_ovf
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [LATENCY-1:0] vld;
   logic [CW-1:0]      credits;
   logic               issue;
   logic               pop;
   logic               push;
   logic               fifo_full;
   logic               fifo_empty;
   fp16_t              fifo_head;

   // A credit stands for one FIFO slot not yet claimed by an in-flight or queued result,
   // so the pipe can never deliver a result with nowhere to put it. s_ready depends only
   // on registered state, keeping m_ready out of the s_ready path.
   assign s_ready = (credits != '0) & ~rst;
   assign issue   = s_valid & s_ready;
   assign pop     = m_valid & m_ready;
   assign push    = vld[LATENCY-1];

   // Idle cycles drive zeros into the pipe
   assign pipe_a  = issue ? s_a : FP16_ZERO;
   assign pipe_b  = issue ? s_b : FP16_ZERO;

   assign m_valid = ~fifo_empty;
   assign m_res   = fifo_head;

   // Token delay line mirroring the pipe depth; its tail marks when pipe_res is meaningful
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
      end else begin
         vld[0] <= issue;
         for (int i = 1; i < LATENCY; i++) begin
            vld[i] <= vld[i-1];
         end
      end
   end

   // Credit counter: an issue consumes a slot, a pop returns one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits <= CW'(FIFO_DEPTH);
      end else if (issue && !pop) begin
         credits <= credits - CW'(1);
      end else if (pop && !issue) begin
         credits <= credits + CW'(1);
      end
   end

   // Sticky flag for a result arriving at a full FIFO; credit admission should rule it out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_ovf <= 1'b0;
      end else if (push && fifo_full) begin
         o_ovf <= 1'b1;
      end
   end

   fp16_res_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FP16_W)
   ) u_res_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (pipe_res),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_fp16pipe_stream.sv
// tb/tb_fp16pipe_stream.sv - randomized self-checking bench for fp16pipe_stream
module tb_fp16pipe_stream;

   localparam int LAT   = 3;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_a;
   logic [15:0] s_b;
   logic [15:0] pipe_a;
   logic [15:0] pipe_b;
   logic [15:0] pipe_res;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_res;
   logic        o_ovf;

   int tests_run = 0;
   int tests_failed = 0;
   int pop_count = 0;
   logic [15:0] exp_q [$];
   logic [15:0] pipe_stage [LAT];

   always #5 clk = ~clk;

   fp16pipe_stream #(
      .LATENCY    (LAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_a      (s_a),
      .s_b      (s_b),
      .pipe_a   (pipe_a),
      .pipe_b   (pipe_b),
      .pipe_res (pipe_res),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_res    (m_res),
      .o_ovf    (o_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic real pow2(input int n);
      real r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else        for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp16_to_real(input logic [15:0] h);
      real v;
      if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
      else                  v = (1024.0 + real'(h[9:0])) * pow2(int'(h[14:10]) - 25);
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] real_to_fp16(input real v);
      logic s;
      real  a, m, frac, r;
      int   e, fi;
      s = (v < 0.0);
      a = s ? -v : v;
      if (a == 0.0) return {s, 15'd0};
      m = a;
      e = 15;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      if (e >= 31) return {s, 5'h1f, 10'd0};
      if (e <= 0) begin
         frac = a * pow2(24);
         fi = $rtoi(frac);
         r = frac - real'(fi);
         if (r > 0.5 || (r == 0.5 && fi[0])) fi++;
         if (fi >= 1024) return {s, 5'd1, 10'd0};
         return {s, 5'd0, fi[9:0]};
      end
      frac = (m - 1.0) * 1024.0;
      fi = $rtoi(frac);
      r = frac - real'(fi);
      if (r > 0.5 || (r == 0.5 && fi[0])) fi++;
      if (fi == 1024) begin fi = 0; e++; end
      if (e >= 31) return {s, 5'h1f, 10'd0};
      return {s, e[4:0], fi[9:0]};
   endfunction

   // IEEE half-precision addition with round-to-nearest-even
   function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
      logic a_nan, b_nan, a_inf, b_inf;
      a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 0);
      b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 0);
      a_inf = (a[14:10] == 5'h1f) && (a[9:0] == 0);
      b_inf = (b[14:10] == 5'h1f) && (b[9:0] == 0);
      if (a_nan || b_nan) return 16'h7E00;
      if (a_inf && b_inf && (a[15] != b[15])) return 16'h7E00;
      if (a_inf) return a;
      if (b_inf) return b;
      if (a[14:0] == 0 && b[14:0] == 0) return {a[15] & b[15], 15'd0};
      return real_to_fp16(fp16_to_real(a) + fp16_to_real(b));
   endfunction

   // Free-running adder pipe standing in for fp16pipe_add
   always @(posedge clk) begin
      pipe_stage[0] <= fp16_add(pipe_a, pipe_b);
      for (int i = 1; i < LAT; i++) pipe_stage[i] <= pipe_stage[i-1];
   end
   assign pipe_res = pipe_stage[LAT-1];

   // Scoreboard: every accepted pair must come back once, in order
   always @(negedge clk) begin
      if (!rst) begin
         if (s_valid && s_ready) exp_q.push_back(fp16_add(s_a, s_b));
         if (m_valid && m_ready) begin
            pop_count++;
            check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("res_order", 32'(m_res), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic send_op(input logic [15:0] a, input logic [15:0] b, output int stalls);
      logic got = 1'b0;
      stalls = 0;
      s_valid = 1'b1;
      s_a = a;
      s_b = b;
      for (int c = 0; c < 500 && !got; c++) begin
         @(negedge clk);
         got = s_ready;
         if (!got) stalls++;
         @(posedge clk);
         #1;
      end
      if (!got) check("send_timeout", 32'(got), 32'd1);
   endtask

   task automatic wait_drain();
      m_ready = 1'b1;
      for (int c = 0; c < 500 && exp_q.size() != 0; c++) begin
         @(posedge clk);
         #1;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic get_result(output logic [15:0] res);
      logic got = 1'b0;
      res = 16'h0;
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge clk);
         if (m_valid) begin
            got = 1'b1;
            res = m_res;
         end
         @(posedge clk);
         #1;
      end
      check("result_timeout", 32'(got), 32'd1);
   endtask

   initial begin
      int st, total, p0, issues, sent, stale;
      logic pending;
      logic [15:0] head, res;
      s_valid = 1'b0;
      s_a = 16'h0;
      s_b = 16'h0;
      m_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_pipe_a", 32'(pipe_a), 32'd0);
      check("rst_pipe_b", 32'(pipe_b), 32'd0);
      check("rst_ovf", 32'(o_ovf), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_s_ready", 32'(s_ready), 32'd1);

      // 1. Single op and its latency
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_a = 16'h3C00;
      s_b = 16'h4000;
      @(negedge clk);
      check("t1_pipe_a", 32'(pipe_a), 32'h3C00);
      check("t1_pipe_b", 32'(pipe_b), 32'h4000);
      @(posedge clk);
      #1 s_valid = 1'b0;
      for (int k = 0; k <= LAT; k++) begin
         @(negedge clk);
         check("t1_latency", 32'(m_valid), 32'(k == LAT));
         if (k == 0) check("t1_idle_pipe_a", 32'(pipe_a), 32'd0);
         if (k < LAT) @(posedge clk);
      end
      check("t1_res", 32'(m_res), 32'h4200);
      @(posedge clk);
      #1;

      // 2. Back-to-back streaming
      total = 0;
      p0 = pop_count;
      for (int i = 0; i < 16; i++) begin
         send_op(16'($urandom), 16'($urandom), st);
         total += st;
      end
      s_valid = 1'b0;
      check("t2_no_stall", 32'(total), 32'd0);
      wait_drain();
      check("t2_count", 32'(pop_count - p0), 32'd16);

      // 3. Backpressure
      m_ready = 1'b0;
      issues = 0;
      for (int c = 0; c < 30; c++) begin
         s_valid = 1'b1;
         s_a = 16'($urandom);
         s_b = 16'($urandom);
         @(negedge clk);
         if (s_ready) issues++;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      check("t3_issues", 32'(issues), 32'(DEPTH));
      @(negedge clk);
      check("t3_s_ready_low", 32'(s_ready), 32'd0);
      check("t3_m_valid", 32'(m_valid), 32'd1);
      head = (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx;
      check("t3_head", 32'(m_res), 32'(head));
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t3_head_stable", 32'(m_res), 32'(head));
      @(posedge clk);
      #1;
      p0 = pop_count;
      wait_drain();
      check("t3_drained", 32'(pop_count - p0), 32'(DEPTH));
      check("t3_ovf", 32'(o_ovf), 32'd0);

      // 4. Random valid/ready, 1000 ops
      sent = 0;
      pending = 1'b0;
      p0 = pop_count;
      for (int c = 0; c < 20000 && sent < 1000; c++) begin
         m_ready = 1'($urandom);
         if (!pending && $urandom_range(1, 0) == 1) begin
            pending = 1'b1;
            s_a = 16'($urandom);
            s_b = 16'($urandom);
         end
         s_valid = pending;
         @(negedge clk);
         if (s_valid && s_ready) begin
            sent++;
            pending = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      check("t4_sent", 32'(sent), 32'd1000);
      wait_drain();
      check("t4_popped", 32'(pop_count - p0), 32'd1000);
      check("t4_ovf", 32'(o_ovf), 32'd0);

      // 5. Reset with two results queued and two in flight
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_op(16'h3C00 + 16'(i), 16'h3C00, st);
      s_valid = 1'b0;
      @(negedge clk);
      check("t5_queued", 32'(m_valid), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      #1;
      check("t5_rst_m_valid", 32'(m_valid), 32'd0);
      check("t5_rst_s_ready", 32'(s_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      check("t5_s_ready_after", 32'(s_ready), 32'd1);
      stale = 0;
      for (int k = 0; k < LAT + 4; k++) begin
         if (m_valid) stale++;
         @(posedge clk);
         @(negedge clk);
      end
      check("t5_no_stale", 32'(stale), 32'd0);
      @(posedge clk);
      #1;
      send_op(16'h4000, 16'h4000, st);
      s_valid = 1'b0;
      get_result(res);
      check("t5_res", 32'(res), 32'h4400);

      // 6. Special values pass through untouched
      send_op(16'h7C00, 16'hFC00, st);
      s_valid = 1'b0;
      get_result(res);
      check("t6_nan_exp", 32'(res[14:10]), 32'h1f);
      check("t6_nan_mant", 32'(res[9:0] != 10'd0), 32'd1);
      send_op(16'h7BFF, 16'h7BFF, st);
      s_valid = 1'b0;
      get_result(res);
      check("t6_ovf_inf", 32'(res), 32'h7C00);

      @(negedge clk);
      check("final_ovf", 32'(o_ovf), 32'd0);
      check("final_queue", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
